// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: words appear on po 1 cycle after the Nth valid bit.
// Backpressure: a word completing while po is held (po_valid & !po_ready) is dropped and flags overrun.
module sipo_deser #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          si,
  input  logic          si_valid,
  input  logic          clear,
  output logic [N-1:0]  po,
  output logic          po_valid,
  input  logic          po_ready,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  logic [N-1:0]  sh_q, sh_d, sh_shift;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  po_q, po_d;
  logic          po_valid_q, po_valid_d;
  logic          overrun_q, overrun_d;
  logic          sample, complete, load, accept;

  assign sample   = si_valid && !clear;
  assign sh_shift = MSB_FIRST ? {sh_q[N-2:0], si} : {si, sh_q[N-1:1]};
  assign complete = sample && (cnt_q == CW'(N-1));
  assign accept   = po_valid_q && po_ready;
  // A completing word may replace the buffered one only if that one leaves this cycle.
  assign load     = complete && (!po_valid_q || po_ready);

  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;

    if (clear) begin
      sh_d      = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (sample) begin
      sh_d  = sh_shift;
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end

    if (load) begin
      po_d       = sh_shift;
      po_valid_d = 1'b1;
    end else if (accept) begin
      po_valid_d = 1'b0;
    end

    if (complete && po_valid_q && !po_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign bit_cnt  = cnt_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: one MSB-first and one LSB-first deserializer driven by the same stimulus.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       reset, si, si_valid, clear, po_ready;
  logic [7:0] po_m, po_l;
  logic       po_valid_m, po_valid_l;
  logic [2:0] bit_cnt_m, bit_cnt_l;
  logic       overrun_m, overrun_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .clear(clear),
    .po(po_m), .po_valid(po_valid_m), .po_ready(po_ready),
    .bit_cnt(bit_cnt_m), .overrun(overrun_m)
  );

  sipo_deser #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .clear(clear),
    .po(po_l), .po_valid(po_valid_l), .po_ready(po_ready),
    .bit_cnt(bit_cnt_l), .overrun(overrun_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    si       = b;
    si_valid = 1'b1;
    step();
    si_valid = 1'b0;
  endtask

  // Bits go out w[7] first; with gaps set, 1..3 idle cycles follow each of the first 7 bits.
  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (gaps && i > 0) begin
        for (int g = 0; g < ((7 - i) % 3) + 1; g++) step();
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    reset = 1'b1; si = 1'b0; si_valid = 1'b0; clear = 1'b0; po_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_po", po_m, 8'h00);
    chk("rst_po_valid", po_valid_m, 1'b0);
    chk("rst_bit_cnt", bit_cnt_m, 3'd0);
    chk("rst_overrun", overrun_m, 1'b0);

    // Back-to-back stream 1,0,1,1,0,0,1,0
    w = 8'hB2;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    chk("b2_cnt7", bit_cnt_m, 3'd7);
    chk("b2_not_yet_valid", po_valid_m, 1'b0);
    send_bit(w[0]);
    chk("b2_msb_po", po_m, 8'hB2);
    chk("b2_msb_valid", po_valid_m, 1'b1);
    chk("b2_cnt_wrap", bit_cnt_m, 3'd0);
    chk("b2_lsb_po", po_l, 8'h4D);
    chk("b2_lsb_valid", po_valid_l, 1'b1);
    step();
    chk("b2_consumed", po_valid_m, 1'b0);
    chk("b2_po_held", po_m, 8'hB2);

    // Same stream with idle gaps
    w = 8'hB2;
    for (int i = 7; i >= 4; i--) begin
      send_bit(w[i]);
      step();
    end
    chk("gap_cnt4", bit_cnt_m, 3'd4);
    step();
    step();
    chk("gap_cnt_hold", bit_cnt_m, 3'd4);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
      if (i > 0) begin
        for (int g = 0; g < (i % 3) + 1; g++) step();
      end
    end
    chk("gap_msb_po", po_m, 8'hB2);
    chk("gap_lsb_po", po_l, 8'h4D);
    chk("gap_valid", po_valid_m, 1'b1);
    step();
    send_word(8'h5A, 1'b1);
    chk("gap2_msb_po", po_m, 8'h5A);
    chk("gap2_lsb_po", po_l, 8'h5A);
    step();

    // Overrun: second word dropped while po is held
    po_ready = 1'b0;
    send_word(8'hB2, 1'b0);
    chk("ovr_first_po", po_m, 8'hB2);
    chk("ovr_first_flag", overrun_m, 1'b0);
    send_word(8'hFF, 1'b0);
    chk("ovr_po_stable", po_m, 8'hB2);
    chk("ovr_valid_held", po_valid_m, 1'b1);
    chk("ovr_flag", overrun_m, 1'b1);
    chk("ovr_lsb_po", po_l, 8'h4D);
    chk("ovr_lsb_flag", overrun_l, 1'b1);
    chk("ovr_cnt", bit_cnt_m, 3'd0);
    po_ready = 1'b1;
    step();
    chk("ovr_drain", po_valid_m, 1'b0);
    chk("ovr_sticky", overrun_m, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ovr_clear", overrun_m, 1'b0);

    // Completion coinciding with consumption replaces po without overrun
    po_ready = 1'b0;
    send_word(8'hB2, 1'b0);
    w = 8'h4D;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    chk("swap_held", po_m, 8'hB2);
    po_ready = 1'b1;
    send_bit(w[0]);
    chk("swap_po", po_m, 8'h4D);
    chk("swap_valid", po_valid_m, 1'b1);
    chk("swap_overrun", overrun_m, 1'b0);
    step();
    chk("swap_drain", po_valid_m, 1'b0);

    // Reset mid-word discards the partial word
    w = 8'hA8;
    for (int i = 7; i >= 3; i--) send_bit(w[i]);
    chk("mid_cnt5", bit_cnt_m, 3'd5);
    reset = 1'b1;
    si = 1'b1;
    si_valid = 1'b1;
    step();
    reset = 1'b0;
    si_valid = 1'b0;
    chk("mid_rst_cnt", bit_cnt_m, 3'd0);
    send_word(8'hF0, 1'b0);
    chk("mid_rst_msb_po", po_m, 8'hF0);
    chk("mid_rst_lsb_po", po_l, 8'h0F);
    chk("mid_rst_valid", po_valid_m, 1'b1);
    step();

    // Clear mid-word, with a valid bit offered during the clear cycle
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("clr_cnt3", bit_cnt_m, 3'd3);
    clear = 1'b1;
    si = 1'b1;
    si_valid = 1'b1;
    step();
    clear = 1'b0;
    si_valid = 1'b0;
    chk("clr_cnt0", bit_cnt_m, 3'd0);
    send_word(8'hF0, 1'b0);
    chk("clr_msb_po", po_m, 8'hF0);
    chk("clr_lsb_po", po_l, 8'h0F);
    chk("clr_valid", po_valid_m, 1'b1);
    chk("clr_cnt_end", bit_cnt_m, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
